// File: rtl/sd_audio_dac.sv
// Multi-channel sigma-delta audio DAC: double-buffered PCM frames in, one
// pulse-density bit per channel out, first- or second-order modulation.
module sd_audio_dac #(
  parameter int CHANNELS = 2,
  parameter int BITS     = 8,
  parameter int ORDER    = 1,
  parameter int SIGNED   = 0,
  parameter int RATE_DIV = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mute,
  input  logic [CHANNELS*BITS-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     tick,
  output logic                     underrun,
  output logic [CHANNELS-1:0]      dout
);

  localparam int DW = $clog2(RATE_DIV);
  localparam logic [BITS-1:0] MID = BITS'(1) << (BITS - 1);

  logic [DW-1:0]            div_cnt_q, div_cnt_d;
  logic                     pend_full_q, pend_full_d;
  logic [CHANNELS*BITS-1:0] pend_q, pend_d;
  logic [CHANNELS*BITS-1:0] active_q, active_d;
  logic                     tick_q, tick_d;
  logic                     underrun_q, underrun_d;
  logic [CHANNELS-1:0]      dout_q, dout_d;
  logic                     tick_now;
  logic                     accept;

  // Handshake: a frame transfers on any cycle where s_valid && s_ready;
  // s_ready opens when the pending slot is empty or is being drained this cycle.
  assign tick_now = en && (div_cnt_q == DW'(RATE_DIV - 1));
  assign s_ready  = !pend_full_q || tick_now;
  assign accept   = s_valid && s_ready;

  assign tick     = tick_q;
  assign underrun = underrun_q;
  assign dout     = dout_q;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    if (en) div_cnt_d = tick_now ? '0 : div_cnt_q + DW'(1);
    if (tick_now && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    // An accept on the draining tick refills the slot immediately.
    if (accept) begin
      pend_d      = s_data;
      pend_full_d = 1'b1;
    end
    tick_d     = tick_now;
    underrun_d = tick_now && !pend_full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      active_q    <= '0;
      tick_q      <= 1'b0;
      underrun_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      active_q    <= active_d;
      tick_q      <= tick_d;
      underrun_q  <= underrun_d;
      dout_q      <= dout_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [BITS-1:0] x, u;
    assign x = active_q[k*BITS +: BITS];
    assign u = mute ? MID : ((SIGNED != 0) ? (x ^ MID) : x);

    if (ORDER == 2) begin : g_o2
      localparam int EW = BITS + 3;
      localparam logic signed [EW-1:0] HALF     = EW'(2 ** (BITS - 1));
      localparam logic signed [EW-1:0] NEG_HALF = -HALF;
      localparam logic signed [EW-1:0] FULL     = EW'(2 ** BITS);

      logic signed [EW-1:0] e1_q, e1_d, e2_q, e2_d, w, e;
      logic                 d;

      always_comb begin
        w = $signed({3'b000, u}) + (e1_q <<< 1) - e2_q;
        d = (w >= HALF);
        e = d ? (w - FULL) : w;
        if (e > HALF) e = HALF;
        else if (e < NEG_HALF) e = NEG_HALF;
        e1_d = en ? e : '0;
        e2_d = en ? e1_q : '0;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          e1_q <= '0;
          e2_q <= '0;
        end else begin
          e1_q <= e1_d;
          e2_q <= e2_d;
        end
      end

      assign dout_d[k] = en && d;
    end else begin : g_o1
      // Any ORDER other than 2 builds the first-order loop; only 1 and 2 are legal.
      // The carry of the BITS+1 sum is the output bit, so only the low bits are kept.
      logic [BITS-1:0] acc_q, acc_d;
      logic [BITS:0]   sum;

      assign sum   = {1'b0, acc_q} + {1'b0, u};
      assign acc_d = en ? sum[BITS-1:0] : '0;

      always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
      end

      assign dout_d[k] = en && sum[BITS];
    end
  end

endmodule
